// File: rtl/bram_stream_reader.sv
// BRAM port-B stream reader: turns (addr, len) commands into sequential reads
// and emits the returned words as an AXI-Stream frame through a credit-controlled skid FIFO.
module bram_stream_reader #(
    parameter int DATA_WIDTH   = 64,
    parameter int DATA_DEPTH   = 2048,
    parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
    parameter int LEN_WIDTH    = 16,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  bram_enb,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [DATA_WIDTH-1:0] bram_doutb,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic                    done_q, done_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;
    logic [DATA_WIDTH-1:0]   mem_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_data_d [FIFO_DEPTH];
    logic                    mem_last_q [FIFO_DEPTH];
    logic                    mem_last_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic                    pop, push, issue;
    logic [CW-1:0]           inflight, occ;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_data_d = mem_data_q;
        mem_last_d = mem_last_q;

        pop  = (count_q != '0) && m_axis_tready;
        push = tag_vld_q[READ_LATENCY-1];

        // Credit: FIFO entries plus reads still in the BRAM pipe, net of this cycle's pop.
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
        occ   = count_q + inflight - CW'(pop);
        issue = (state_q == ISSUE) && (occ < CW'(FIFO_DEPTH));

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && mem_last_q[rd_ptr_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        tag_vld_d[0]  = issue;
        tag_last_d[0] = issue && (rem_q == LEN_WIDTH'(1));
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end

        if (push) begin
            mem_data_d[wr_ptr_q] = bram_doutb;
            mem_last_d[wr_ptr_q] = tag_last_q[READ_LATENCY-1];
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            mem_data_q <= '{default: '0};
            mem_last_q <= '{default: 1'b0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            tag_vld_q  <= tag_vld_d;
            tag_last_q <= tag_last_d;
            mem_data_q <= mem_data_d;
            mem_last_q <= mem_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign bram_enb      = issue;
    assign bram_addrb    = addr_q;
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = mem_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && mem_last_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 2-cycle-latency BRAM model
// whose word at address a is a known function of a.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        bram_enb;
    logic [10:0] bram_addrb;
    logic [63:0] bram_doutb = '0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;

    bram_stream_reader #(
        .DATA_WIDTH(64), .DATA_DEPTH(2048), .ADDR_WIDTH(11),
        .LEN_WIDTH(16), .READ_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] f(input logic [10:0] a);
        return {32'hC0DE_5A5A, 21'd0, a};
    endfunction

    logic [63:0] p1 = '0;
    always @(posedge clk) begin
        if (bram_enb) p1 <= f(bram_addrb);
        bram_doutb <= p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] beat_data[$];
    logic        beat_last[$];
    int          beat_cyc[$];
    logic [10:0] enb_addr[$];
    int          enb_cyc[$];
    int          done_cyc[$];
    int          n_enb, n_pop, max_out, stab_err;
    logic        stall_prev;
    logic [63:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst_n) begin
            if (n_enb - n_pop > max_out) max_out = n_enb - n_pop;
            if (stall_prev && m_axis_tvalid &&
                (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)) stab_err++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_data.push_back(m_axis_tdata);
                beat_last.push_back(m_axis_tlast);
                beat_cyc.push_back(cyc);
                n_pop++;
            end
            if (bram_enb) begin
                enb_addr.push_back(bram_addrb);
                enb_cyc.push_back(cyc);
                n_enb++;
            end
            if (done) done_cyc.push_back(cyc);
        end else begin
            stall_prev = 1'b0;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        beat_data.delete(); beat_last.delete(); beat_cyc.delete();
        enb_addr.delete(); enb_cyc.delete(); done_cyc.delete();
        n_enb = 0; n_pop = 0; max_out = 0; stab_err = 0;
    endtask

    task automatic check_frame(input string tag, input logic [10:0] a0, input int len);
        check({tag, "_beats"}, 64'(beat_data.size()), 64'(len));
        for (int i = 0; i < len && i < beat_data.size(); i++) begin
            check({tag, "_data"}, beat_data[i], f(a0 + 11'(i)));
            check({tag, "_last"}, 64'(beat_last[i]), 64'(i == len - 1));
        end
    endtask

    logic [3:0] pat = 4'b1001;
    int c0, hs;
    int hs_cyc[2];

    initial begin
        clear();
        stall_prev = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_enb", 64'(bram_enb), 64'd0);
        check("rst_addrb", 64'(bram_addrb), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Basic frame, addr 0x010 len 4
        m_axis_tready = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 11'h010; cmd_len = 16'd4;
        c0 = cyc;
        tick();
        cmd_valid = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (12) tick();
        check("t1_enb_count", 64'(enb_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < enb_addr.size(); i++) begin
            check("t1_enb_addr", 64'(enb_addr[i]), 64'(11'h010 + 11'(i)));
            check("t1_enb_cyc", 64'(enb_cyc[i]), 64'(c0 + 1 + i));
        end
        check_frame("t1", 11'h010, 4);
        for (int i = 0; i < 4 && i < beat_cyc.size(); i++)
            check("t1_beat_cyc", 64'(beat_cyc[i]), 64'(c0 + 4 + i));
        check("t1_done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) check("t1_done_cyc", 64'(done_cyc[0]), 64'(c0 + 8));
        check("t1_idle", 64'(busy), 64'd0);
        clear();

        // Address wrap
        cmd_valid = 1'b1; cmd_addr = 11'd2046; cmd_len = 16'd4;
        tick();
        cmd_valid = 1'b0;
        repeat (12) tick();
        check("t2_enb_count", 64'(enb_addr.size()), 64'd4);
        if (enb_addr.size() == 4) begin
            check("t2_addr0", 64'(enb_addr[0]), 64'd2046);
            check("t2_addr1", 64'(enb_addr[1]), 64'd2047);
            check("t2_addr2", 64'(enb_addr[2]), 64'd0);
            check("t2_addr3", 64'(enb_addr[3]), 64'd1);
        end
        check_frame("t2", 11'd2046, 4);
        clear();

        // Backpressure 1,0,0,1
        cmd_valid = 1'b1; cmd_addr = 11'h100; cmd_len = 16'd16;
        for (int k = 0; k < 100; k++) begin
            m_axis_tready = pat[k % 4];
            tick();
            cmd_valid = 1'b0;
        end
        m_axis_tready = 1'b1;
        repeat (5) tick();
        check_frame("t3", 11'h100, 16);
        check("t3_stable", 64'(stab_err), 64'd0);
        check("t3_credit_le4", 64'(max_out <= 4), 64'd1);
        check("t3_done_count", 64'(done_cyc.size()), 64'd1);
        clear();

        // Zero-length command
        cmd_valid = 1'b1; cmd_addr = 11'h055; cmd_len = 16'd0;
        c0 = cyc;
        tick();
        cmd_valid = 1'b0;
        check("t4_done", 64'(done), 64'd1);
        check("t4_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        tick();
        check("t4_done_pulse", 64'(done), 64'd0);
        repeat (6) tick();
        check("t4_no_enb", 64'(enb_addr.size()), 64'd0);
        check("t4_no_beat", 64'(beat_data.size()), 64'd0);
        check("t4_done_count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) check("t4_done_cyc", 64'(done_cyc[0]), 64'(c0 + 1));
        clear();

        // Back-to-back commands with cmd_valid held
        cmd_valid = 1'b1; cmd_addr = 11'h200; cmd_len = 16'd3;
        hs = 0;
        for (int k = 0; k < 40 && hs < 2; k++) begin
            if (cmd_ready) begin hs_cyc[hs] = cyc; hs++; end
            tick();
            if (hs == 1) begin cmd_addr = 11'h300; cmd_len = 16'd2; end
            if (hs == 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("t5_two_handshakes", 64'(hs), 64'd2);
        if (hs == 2) check("t5_hs2_cyc", 64'(hs_cyc[1]), 64'(hs_cyc[0] + 7));
        repeat (12) tick();
        check("t5_beats", 64'(beat_data.size()), 64'd5);
        if (beat_data.size() == 5) begin
            check("t5_d0", beat_data[0], f(11'h200));
            check("t5_d2", beat_data[2], f(11'h202));
            check("t5_d3", beat_data[3], f(11'h300));
            check("t5_d4", beat_data[4], f(11'h301));
            check("t5_lasts", 64'({beat_last[0], beat_last[1], beat_last[2],
                                   beat_last[3], beat_last[4]}), 64'b00101);
        end
        check("t5_done_count", 64'(done_cyc.size()), 64'd2);
        if (done_cyc.size() > 0 && hs == 2) check("t5_done_eq_hs2", 64'(done_cyc[0]), 64'(hs_cyc[1]));
        clear();

        // Reset during the third beat of a len=8 frame
        cmd_valid = 1'b1; cmd_addr = 11'h400; cmd_len = 16'd8;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("t6_tvalid_drop", 64'(m_axis_tvalid), 64'd0);
        check("t6_busy_clr", 64'(busy), 64'd0);
        check("t6_enb_clr", 64'(bram_enb), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_pre_beats", 64'(beat_data.size()), 64'd2);
        check("t6_no_done", 64'(done_cyc.size()), 64'd0);
        clear();
        cmd_valid = 1'b1; cmd_addr = 11'h7A0; cmd_len = 16'd2;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        check_frame("t6", 11'h7A0, 2);
        check("t6_done_count", 64'(done_cyc.size()), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
